// File: rtl/nv_memory.sv
// Flash-style word memory: single-cycle reads, multi-cycle AND-only program,
// and sector erase one word per clock. Array contents survive rst_n.
module nv_memory #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 18,
   parameter int SECTOR_W    = 8,
   parameter int PROG_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] d_in,
   input  logic              w_en,
   input  logic              r_en,
   input  logic              er_en,
   output logic [DATA_W-1:0] d_out,
   output logic              d_valid,
   output logic              busy,
   output logic              err
);

   localparam int CNT_W = $clog2(PROG_CYCLES + 1);
   localparam logic [CNT_W-1:0] PROG_LOAD = CNT_W'(PROG_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] OFFS_MASK = {ADDR_W{1'b1}} >> (ADDR_W - SECTOR_W);

   typedef enum logic [1:0] {
      IDLE,
      PROG,
      ERASE
   } state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [ADDR_W-1:0]   op_addr_reg, op_addr_next;
   logic [DATA_W-1:0]   prog_data_reg, prog_data_next;
   logic [SECTOR_W-1:0] offset_reg, offset_next;
   logic                err_reg, err_next;
   logic                valid_reg, valid_next;
   logic [DATA_W-1:0]   hold_reg;

   // Words are stored inverted so a zero power-up state reads back as erased.
   logic [DATA_W-1:0]   mem [2**ADDR_W];
   logic [DATA_W-1:0]   rd_q_reg;

   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;

   logic                cmd_any;
   logic                cmd_multi;

   assign cmd_any   = w_en | r_en | er_en;
   assign cmd_multi = (w_en & r_en) | (w_en & er_en) | (r_en & er_en);

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      op_addr_next   = op_addr_reg;
      prog_data_next = prog_data_reg;
      offset_next    = offset_reg;
      err_next       = 1'b0;
      valid_next     = 1'b0;
      rd_en          = 1'b0;
      rd_addr        = addr;
      wr_en          = 1'b0;
      wr_addr        = op_addr_reg;
      wr_data        = '0;

      case (state_reg)
         IDLE: begin
            if (cs && cmd_multi) begin
               err_next = 1'b1;
            end else if (cs && r_en) begin
               rd_en      = 1'b1;
               valid_next = 1'b1;
            end else if (cs && w_en) begin
               // Fetch the current word now; the commit merges into it.
               rd_en          = 1'b1;
               state_next     = PROG;
               cnt_next       = PROG_LOAD;
               op_addr_next   = addr;
               prog_data_next = d_in;
            end else if (cs && er_en) begin
               state_next   = ERASE;
               offset_next  = '0;
               op_addr_next = addr & ~OFFS_MASK;
            end
         end

         PROG: begin
            err_next = cs & cmd_any;
            rd_en    = 1'b1;
            rd_addr  = op_addr_reg;
            if (cnt_reg == CNT_LAST) begin
               // Inverted storage: clearing a logical bit sets a stored bit.
               wr_en      = 1'b1;
               wr_data    = rd_q_reg | ~prog_data_reg;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end

         ERASE: begin
            err_next    = cs & cmd_any;
            wr_en       = 1'b1;
            wr_addr     = op_addr_reg | ADDR_W'(offset_reg);
            wr_data     = '0;
            offset_next = offset_reg + 1'b1;
            if (&offset_reg) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         op_addr_reg   <= '0;
         prog_data_reg <= '0;
         offset_reg    <= '0;
         err_reg       <= 1'b0;
         valid_reg     <= 1'b0;
         hold_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         op_addr_reg   <= op_addr_next;
         prog_data_reg <= prog_data_next;
         offset_reg    <= offset_next;
         err_reg       <= err_next;
         valid_reg     <= valid_next;
         if (valid_reg) begin
            hold_reg <= ~rd_q_reg;
         end
      end
   end

   // Array port: no reset, so contents persist and the block maps onto RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_q_reg <= mem[rd_addr];
      end
   end

   // Fresh read data is shown straight from the RAM register; it is then held.
   assign d_out   = valid_reg ? ~rd_q_reg : hold_reg;
   assign d_valid = valid_reg;
   assign busy    = (state_reg != IDLE);
   assign err     = err_reg;

endmodule

// File: doc/nv_memory.md
# nv_memory

Parametrised non-volatile (flash-style) memory that succeeds the fixed 8-bit × 256K-word `memory` block. It adds multi-cycle program, sector erase, a busy/error handshake and reset-persistent contents. It sits behind the same chip-select / enable bus as `memory` and is the storage target for the NVM path of the design.

## Interface
- `DATA_W`, 8, word width in bits.
- `ADDR_W`, 18, word-address width; depth is 2^ADDR_W.
- `SECTOR_W`, 8, log2 of words per erase sector; 1 ≤ SECTOR_W ≤ ADDR_W.
- `PROG_CYCLES`, 4, program busy duration in clocks; must be ≥ 1.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cs`  in  1  chip select; when low, all enables are ignored.
- `addr`  in  ADDR_W  word address (read/program) or any address inside the target sector (erase).
- `d_in`  in  DATA_W  program data.
- `w_en`  in  1  program request.
- `r_en`  in  1  read request.
- `er_en`  in  1  sector-erase request.
- `d_out`  out  DATA_W  read data (registered).
- `d_valid`  out  1  one-cycle pulse; `d_out` is updated this cycle.
- `busy`  out  1  program or erase in progress.
- `err`  out  1  one-cycle pulse marking a rejected command.

## Operation
- **Array initial state.**
  - Array starts all-ones (erased) at time zero.
  - `rst_n` never touches the array; contents persist across reset.
- **Reset values.** `d_out`=0, `d_valid`=0, `busy`=0, `err`=0. The FSM enters IDLE and the erase counter clears.
- **FSM states:** IDLE, PROG, ERASE.
- **Command sampling.** A command is sampled at a rising edge only when `cs`=1, in IDLE, and `busy`=0.
- **Enable checks.**
  - Exactly one of `w_en`/`r_en`/`er_en` asserted: the command is accepted.
  - More than one asserted: `err` pulses and nothing else happens.
  - None asserted: no action.
- **Read (IDLE only).** `d_out` <= mem[addr] and `d_valid` pulses. `d_out` holds its value until the next accepted read.
- **Program.**
  - Latch `addr` and `d_in`, go to PROG, load a counter with PROG_CYCLES.
  - Commit on the final cycle: mem[a] <= mem[a] & d. Program can only clear bits (1→0); setting a bit requires an erase.
- **Erase.**
  - Latch sector = addr[ADDR_W-1:SECTOR_W] and go to ERASE.
  - Write all-ones to one word per cycle, offsets 0 … 2^SECTOR_W−1.
  - Return to IDLE after the last offset.
- **Command while busy.** Any enable with `cs`=1 while `busy`=1 makes `err` pulse. The command is dropped and the operation in progress is unaffected.
- **Chip deselected.** `cs`=0 produces no `err` and no action.
- **Reset mid-operation.**
  - PROG aborts and the word is unchanged, because the commit only happens on the last cycle.
  - ERASE aborts: words already erased stay erased, and the remaining words of the sector are untouched.
- **Wrap-around.** The erase offset counter is SECTOR_W bits wide. Erase never crosses a sector boundary; the top sector has no special case.

## Timing
- **Read.** Accepted at edge T; `d_out` and `d_valid` are valid after edge T, i.e. in cycle T+1 (1-cycle latency). Back-to-back reads are accepted every cycle.
- **Program.**
  - Accepted at edge T; `busy`=1 from T.
  - Array commit and `busy` fall both happen at edge T+PROG_CYCLES.
  - Earliest next accepted command is at edge T+PROG_CYCLES+1.
- **Erase.**
  - Accepted at edge T; `busy`=1 from T.
  - Words are erased at edges T+1 … T+2^SECTOR_W, and `busy` falls at edge T+2^SECTOR_W.
  - Next command is accepted at T+2^SECTOR_W+1.
- **err.** High for exactly the cycle following the offending edge; it is not sticky.
- **Read during PROG/ERASE.** Rejected with `err`; `d_out` keeps its old value.

## Test plan
Bench parameters: SECTOR_W=4 (16-word sectors), PROG_CYCLES=4, DATA_W=8, ADDR_W=18.
1. **Power-up read.** Release reset; read addr 0 → `d_out`=8'hFF, `d_valid` one cycle; `busy`=0 and `err`=0 throughout.
2. **Program and AND semantics.**
   - Program addr 1 with 8'h0A → `busy` high exactly 4 cycles; read addr 1 → 8'h0A.
   - Program addr 1 with 8'hF5 → read returns 8'h00.
3. **Commands while busy and illegal combinations.**
   - Program addr 3 with 8'h05; on the next cycle issue a read and a program to addr 4 → `err` pulses each time.
   - After `busy` falls, addr 3 = 8'h05 and addr 4 = 8'hFF.
   - `w_en`=`r_en`=1 in IDLE → `err`=1 for one cycle; no `d_valid`, no `busy`.
4. **Sector erase.**
   - Program addr 1 = 8'h00 and addr 16 = 8'h3C; erase with addr=18'd5 → `busy` high 16 cycles.
   - Then addr 1 reads 8'hFF and addr 16 reads 8'h3C (other sector untouched).
5. **Reset mid-program and persistence.**
   - Program addr 2 with 8'h00; assert `rst_n`=0 two cycles in → outputs return to reset values; addr 2 reads 8'hFF.
   - Pulse reset again; addr 16 still reads 8'h3C.
6. **Reset mid-erase.** Erase sector 1 (addr 18'd16) and reset after 8 busy cycles → addrs 16–23 read 8'hFF; any word in 24–31 programmed beforehand (e.g. addr 24 = 8'h11) keeps its value.
